// File: rtl/led_sequence_ctrl_pkg.sv
// Shared types and constants for the LED sequencer.
//   state_e  : sequencer states (IDLE / RUN / PAUSED)
//   LED_N    : width of the LED bank
//   entry_w  : width of one packed table entry {pattern, duration}
package led_sequence_ctrl_pkg;

  localparam int unsigned LED_N = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  // Packed table entry width for a given duration field width.
  function automatic int unsigned entry_w(input int unsigned dur_w);
    return LED_N + dur_w;
  endfunction

endpackage

// File: rtl/led_sequence_ctrl_if.sv
// Control/config/status bundle between board control logic and the sequencer.
//   master : control side (drives start/stop/pause/loop and table writes)
//   slave  : sequencer side (drives led/busy/done/step/cfg_err)
interface led_sequence_ctrl_if #(
  parameter int unsigned NUM_STEPS = 8,
  parameter int unsigned DUR_W     = 16
);
  import led_sequence_ctrl_pkg::*;

  localparam int unsigned AW = $clog2(NUM_STEPS);

  logic             start;
  logic             stop;
  logic             pause;
  logic             loop;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [LED_N-1:0] cfg_pattern;
  logic [DUR_W-1:0] cfg_dur;
  logic [LED_N-1:0] led;
  logic             busy;
  logic             done;
  logic [AW-1:0]    step;
  logic             cfg_err;

  modport master (
    output start, stop, pause, loop, cfg_we, cfg_addr, cfg_pattern, cfg_dur,
    input  led, busy, done, step, cfg_err
  );

  modport slave (
    input  start, stop, pause, loop, cfg_we, cfg_addr, cfg_pattern, cfg_dur,
    output led, busy, done, step, cfg_err
  );

endinterface

// File: rtl/led_sequence_ctrl_tick_prescaler.sv
// Generic tick prescaler: counts 0..TICK_DIV-1 while en is high and flags
// the terminal count on tick. clr has priority over en.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable (also gates tick)
//   clr        : synchronous clear to 0
//   tick       : high in the cycle the count equals TICK_DIV-1 while enabled
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 12_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;
  logic          last_c;

  assign last_c = (cnt_q == CW'(TICK_DIV - 1));
  assign tick   = en && last_c;

  // Free-running divider, frozen while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= last_c ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/led_sequence_ctrl.sv
// Programmable LED sequencer: plays a table of (pattern, duration) entries,
// durations counted in prescaled ticks, with start/stop/pause/loop control.
//   clk, rst_n : clock, async active-low reset (also clears the table)
//   bus        : slave side of led_sequence_ctrl_if
//                in : start, stop, pause, loop, cfg_we, cfg_addr, cfg_pattern, cfg_dur
//                out: led, busy, done, step, cfg_err (all registered)
module led_sequence_ctrl
  import led_sequence_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 12_000,
  parameter int unsigned NUM_STEPS = 8,
  parameter int unsigned DUR_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  led_sequence_ctrl_if.slave  bus
);

  localparam int unsigned AW      = $clog2(NUM_STEPS);
  localparam int unsigned ENTRY_W = entry_w(DUR_W);

  logic [ENTRY_W-1:0] tbl_q [NUM_STEPS];

  state_e             state_q, state_d;
  logic [LED_N-1:0]   led_q, led_d;
  logic [AW-1:0]      step_q, step_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;

  logic               tick;
  logic               presc_clr_c;
  logic               tbl_we_c;
  logic               start_c;
  logic               active_c;
  logic               step_end_c;
  logic               adv_c;
  logic [AW-1:0]      nxt_idx_c;
  logic [LED_N-1:0]   pat0_c, nxt_pat_c;
  logic [DUR_W-1:0]   dur0_c, cur_dur_c, nxt_dur_c;

  // Table is writable only while idle; STOP beats START.
  assign tbl_we_c = bus.cfg_we && (state_q == ST_IDLE);
  assign start_c  = bus.start && !bus.stop && (state_q == ST_IDLE);

  // Entry 0 seen through a same-cycle write, so START+CFG_WE plays the new entry.
  always_comb begin
    pat0_c = tbl_q[0][ENTRY_W-1 -: LED_N];
    dur0_c = tbl_q[0][DUR_W-1:0];
    if (tbl_we_c && (bus.cfg_addr == '0)) begin
      pat0_c = bus.cfg_pattern;
      dur0_c = bus.cfg_dur;
    end
  end

  assign cur_dur_c = tbl_q[step_q][DUR_W-1:0];
  assign nxt_idx_c = step_q + AW'(1);
  assign nxt_pat_c = tbl_q[nxt_idx_c][ENTRY_W-1 -: LED_N];
  assign nxt_dur_c = tbl_q[nxt_idx_c][DUR_W-1:0];

  // Counting is live whenever busy and not frozen, so a PAUSED cycle with
  // pause released already counts; the frozen span equals the pause length.
  assign active_c   = (state_q != ST_IDLE) && !bus.pause && !bus.stop;
  assign step_end_c = active_c && tick && (dur_cnt_q == cur_dur_c - DUR_W'(1));
  // Next index exists (no wrap past the last slot) and is not an end marker.
  assign adv_c      = (step_q != AW'(NUM_STEPS - 1)) && (nxt_dur_c != '0);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (active_c),
    .clr   (presc_clr_c),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_c && (dur0_c != '0)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_PAUSED: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (step_end_c) begin
          state_d = (adv_c || bus.loop) ? ST_RUN : ST_IDLE;
        end else if (bus.pause) begin
          state_d = ST_PAUSED;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    led_d       = led_q;
    step_d      = step_q;
    done_d      = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    cfg_err_d   = bus.cfg_we && (state_q != ST_IDLE);
    dur_cnt_d   = dur_cnt_q;
    presc_clr_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          if (dur0_c != '0) begin
            led_d       = pat0_c;
            step_d      = '0;
            dur_cnt_d   = '0;
            presc_clr_c = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN, ST_PAUSED: begin
        if (bus.stop) begin
          led_d       = '0;
          step_d      = '0;
          dur_cnt_d   = '0;
          presc_clr_c = 1'b1;
        end else if (step_end_c) begin
          dur_cnt_d   = '0;
          presc_clr_c = 1'b1;
          if (adv_c) begin
            step_d = nxt_idx_c;
            led_d  = nxt_pat_c;
          end else if (bus.loop) begin
            step_d = '0;
            led_d  = tbl_q[0][ENTRY_W-1 -: LED_N];
          end else begin
            step_d = '0;
            led_d  = '0;
            done_d = 1'b1;
          end
        end else if (active_c && tick) begin
          dur_cnt_d = dur_cnt_q + DUR_W'(1);
        end
      end
      default: begin
        led_d  = '0;
        step_d = '0;
      end
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= '0;
      step_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      dur_cnt_q <= '0;
    end else begin
      led_q     <= led_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      dur_cnt_q <= dur_cnt_d;
    end
  end

  // Sequence table (register array, async read).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_STEPS); i++) begin
        tbl_q[i] <= '0;
      end
    end else if (tbl_we_c) begin
      tbl_q[bus.cfg_addr] <= {bus.cfg_pattern, bus.cfg_dur};
    end
  end

  assign bus.led     = led_q;
  assign bus.step    = step_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cfg_err = cfg_err_q;

endmodule
